lfsr_seq_ctrl: RTL and testbench
================================

LFSR_SEQ_CTRL -- requirements
Module: lfsr_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, LFSR width and result word width; only 8 is supported.
REQ-002 Parameter: CNT_W, 8, width of shift_cycles and of the internal run counter.
REQ-003 clk  in  1  single clock; all state updates occur on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  request one seed/run/unload sequence; sampled only in IDLE.
REQ-006 seed_in  in  WIDTH  seed value; latched on the edge that accepts start.
REQ-007 shift_cycles  in  CNT_W  number N of LFSR advance cycles; latched with seed_in.
REQ-008 lfsr_seed  out  WIDTH  seed value driven to the LFSR datapath.
REQ-009 lfsr_rst_n  out  1  active-low reseed strobe to the LFSR datapath.
REQ-010 lfsr_enable  out  1  LFSR advance command.
REQ-011 lfsr_out_enable  out  1  LFSR serial unload command.
REQ-012 lfsr_out  in  1  registered serial bit from the LFSR, LSB first.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 word_out  out  WIDTH  reassembled LFSR value.
REQ-015 word_valid  out  1  word_out is valid; held until accepted.
REQ-016 word_ready  in  1  consumer accepts word_out when high with word_valid.

Function
REQ-017 All outputs SHALL be registered, and no output SHALL depend combinationally on any input.
REQ-018 FSM states SHALL be IDLE, SEED, RUN, UNLOAD, DRAIN and HOLD.
REQ-019 IDLE: on start=1, latch seed_in and shift_cycles, then go to SEED; otherwise remain in IDLE.
REQ-020 SEED: lasts exactly 1 cycle with lfsr_rst_n=0 and lfsr_seed=latched seed, then goes to RUN if N>0 or to UNLOAD if N=0.
REQ-021 RUN: lfsr_enable=1 for exactly N consecutive cycles, counted by a CNT_W down-counter, then go to UNLOAD; N=255 SHALL give 255 cycles with no wrap.
REQ-022 UNLOAD: lfsr_out_enable=1 for exactly 8 cycles, then go to DRAIN.
REQ-023 lfsr_enable and lfsr_out_enable SHALL never be high in the same cycle.
REQ-024 Capture: in each cycle following an lfsr_out_enable=1 cycle, an internal shift register SHALL load {lfsr_out, sr[7:1]}, giving exactly 8 captures, the last of them in DRAIN.
REQ-025 DRAIN: lasts 1 cycle, then goes to HOLD; word_out SHALL be updated from the shift register on entry to HOLD.
REQ-026 HOLD: word_valid=1 and word_out stable; on word_valid&word_ready, go to IDLE and clear word_valid on the same edge.
REQ-027 Latency: word_valid SHALL rise exactly N+10 rising edges after the edge that samples start.
REQ-028 start SHALL be ignored while busy=1, including in HOLD, and SHALL NOT be queued.
REQ-029 word_out SHALL equal the LFSR register contents at the end of RUN, because bit 0 is shifted out first.
REQ-030 A start that is high in IDLE on the cycle after a HOLD handshake SHALL be accepted, which allows back-to-back sequences.

Reset
REQ-031 reset=1 SHALL force, asynchronously: state=IDLE, lfsr_rst_n=0, lfsr_seed=0, lfsr_enable=0, lfsr_out_enable=0, busy=0, word_valid=0, word_out=0, and counters and the shift register to 0.
REQ-032 lfsr_rst_n SHALL return to 1 on the first clock edge after reset deasserts.
REQ-033 A reset during any state SHALL abort the sequence and discard partial captures, and no word_valid SHALL follow it.

Verification
REQ-034 seed_in=0x01, N=0, start -> word_valid after 10 edges, word_out=0x01.
REQ-035 seed_in=0x01, N=3 -> lfsr_enable high for exactly 3 cycles, word_out=0x08, word_valid at edge 13.
REQ-036 seed_in=0x00, N=1 -> word_out=0xAB (all-zero escape through the feedback).
REQ-037 word_ready held low for 20 cycles in HOLD with start pulsed repeatedly -> word_valid and word_out stable, busy=1, no restart; word_ready=1 -> IDLE next edge.
REQ-038 reset asserted mid-UNLOAD (after 4 out_enable cycles) -> all outputs at reset values immediately; after release, a new start with seed_in=0x80, N=0 -> word_out=0x80.
REQ-039 N=255 -> exactly 255 lfsr_enable cycles, word_valid at edge 265; lfsr_enable and lfsr_out_enable are never both high (assertion).

Source files
------------

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer for an external 8-bit LFSR: seeds it, advances it N cycles, then
// unloads it serially (LSB first) and presents the reassembled word with a valid/ready handshake.
module lfsr_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] seed_in_i,
  input  logic [CNT_W-1:0] shift_cycles_i,
  output logic [WIDTH-1:0] lfsr_seed_o,
  output logic             lfsr_rst_n_o,
  output logic             lfsr_enable_o,
  output logic             lfsr_out_enable_o,
  input  logic             lfsr_out_i,
  output logic             busy_o,
  output logic [WIDTH-1:0] word_out_o,
  output logic             word_valid_o,
  input  logic             word_ready_i
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEED   = 3'd1,
    RUN    = 3'd2,
    UNLOAD = 3'd3,
    DRAIN  = 3'd4,
    HOLD   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] UNLOAD_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             cap_q;
  logic             rst_n_q, en_q, oe_q, busy_q, valid_q;

  // Next-state, counter, seed latch and capture shift register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seed_d  = seed_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SEED;
          seed_d  = seed_in_i;
          cnt_d   = shift_cycles_i;
        end else begin
          state_d = IDLE;
        end
      end
      SEED: begin
        if (cnt_q != '0) begin
          state_d = RUN;
        end else begin
          state_d = UNLOAD;
          cnt_d   = UNLOAD_LAST;
        end
      end
      RUN: begin
        // The counter is reused for the unload phase once the run completes.
        if (cnt_q == CNT_ONE) begin
          state_d = UNLOAD;
          cnt_d   = UNLOAD_LAST;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      UNLOAD: begin
        if (cnt_q == '0) begin
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DRAIN: state_d = HOLD;
      HOLD: begin
        if (word_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase

    // lfsr_out lags lfsr_out_enable by one cycle, so capture uses the delayed enable.
    if (cap_q) begin
      sr_d = {lfsr_out_i, sr_q[WIDTH-1:1]};
    end else begin
      sr_d = sr_q;
    end

    if (state_q == DRAIN) begin
      word_d = sr_d;
    end else begin
      word_d = word_q;
    end
  end

  // State, datapath and output registers; outputs are decoded from the next state.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      seed_q  <= '0;
      sr_q    <= '0;
      word_q  <= '0;
      cap_q   <= 1'b0;
      rst_n_q <= 1'b0;
      en_q    <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seed_q  <= seed_d;
      sr_q    <= sr_d;
      word_q  <= word_d;
      cap_q   <= oe_q;
      rst_n_q <= (state_d != SEED);
      en_q    <= (state_d == RUN);
      oe_q    <= (state_d == UNLOAD);
      busy_q  <= (state_d != IDLE);
      valid_q <= (state_d == HOLD);
    end
  end

  assign lfsr_seed_o       = seed_q;
  assign lfsr_rst_n_o      = rst_n_q;
  assign lfsr_enable_o     = en_q;
  assign lfsr_out_enable_o = oe_q;
  assign busy_o            = busy_q;
  assign word_out_o        = word_q;
  assign word_valid_o      = valid_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl with a behavioural external LFSR datapath.
module tb_lfsr_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] seed_in;
  logic [7:0] shift_cycles;
  logic [7:0] lfsr_seed;
  logic       lfsr_rst_n;
  logic       lfsr_enable;
  logic       lfsr_out_enable;
  logic       lfsr_out;
  logic       busy;
  logic [7:0] word_out;
  logic       word_valid;
  logic       word_ready;

  int n_checks = 0;
  int n_fails  = 0;
  int excl_viol = 0;

  lfsr_seq_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .start_i           (start),
    .seed_in_i         (seed_in),
    .shift_cycles_i    (shift_cycles),
    .lfsr_seed_o       (lfsr_seed),
    .lfsr_rst_n_o      (lfsr_rst_n),
    .lfsr_enable_o     (lfsr_enable),
    .lfsr_out_enable_o (lfsr_out_enable),
    .lfsr_out_i        (lfsr_out),
    .busy_o            (busy),
    .word_out_o        (word_out),
    .word_valid_o      (word_valid),
    .word_ready_i      (word_ready)
  );

  always #5 clk = ~clk;

  // Galois LFSR with zero-state escape: 0x00 -> 0xAB, 0x01 -> 0x02 ...
  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    logic fb;
    fb = x[7] ^ (x[6:0] == 7'd0);
    return {x[6:0], 1'b0} ^ (fb ? 8'hAB : 8'h00);
  endfunction

  logic [7:0] lfsr_reg;
  always @(posedge clk) begin
    if (!lfsr_rst_n) begin
      lfsr_reg <= lfsr_seed;
      lfsr_out <= 1'b0;
    end else if (lfsr_enable) begin
      lfsr_reg <= lfsr_step(lfsr_reg);
    end else if (lfsr_out_enable) begin
      lfsr_out <= lfsr_reg[0];
      lfsr_reg <= {1'b0, lfsr_reg[7:1]};
    end
  end

  always @(negedge clk) begin
    if (lfsr_enable && lfsr_out_enable) excl_viol++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_seq(input logic [7:0] seed, input logic [7:0] n,
                         input logic [7:0] exp_w, input int hold_cyc, input string tag);
    int edges, en_cnt, oe_cnt, bad;
    @(negedge clk);
    seed_in = seed; shift_cycles = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; edges = 0; en_cnt = 0; oe_cnt = 0;
    while (!word_valid && edges < 400) begin
      if (lfsr_enable) en_cnt++;
      if (lfsr_out_enable) oe_cnt++;
      @(posedge clk); #1;
      edges++;
    end
    check_val({tag, "_latency"}, edges, 32'(n) + 32'd10);
    check_val({tag, "_en_cycles"}, en_cnt, 32'(n));
    check_val({tag, "_oe_cycles"}, oe_cnt, 32'd8);
    check_val({tag, "_word"}, {24'd0, word_out}, {24'd0, exp_w});
    check_val({tag, "_busy_hold"}, {31'd0, busy}, 32'd1);
    bad = 0;
    for (int i = 0; i < hold_cyc; i++) begin
      @(negedge clk);
      start = (i % 2 == 0);
      @(posedge clk); #1;
      if (!word_valid || word_out !== exp_w || !busy) bad++;
    end
    start = 1'b0;
    if (hold_cyc > 0) check_val({tag, "_hold_stable"}, bad, 32'd0);
    word_ready = 1'b1;
    @(posedge clk); #1;
    word_ready = 1'b0;
    check_val({tag, "_valid_clr"}, {31'd0, word_valid}, 32'd0);
    check_val({tag, "_busy_clr"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int oe_cnt, k, bad;
    logic [7:0] exp255;
    reset = 1'b1; start = 1'b0; seed_in = 8'd0; shift_cycles = 8'd0; word_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_lfsr_rst_n", {31'd0, lfsr_rst_n}, 32'd0);
    check_val("rst_seed", {24'd0, lfsr_seed}, 32'd0);
    check_val("rst_enable", {31'd0, lfsr_enable}, 32'd0);
    check_val("rst_out_enable", {31'd0, lfsr_out_enable}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_valid", {31'd0, word_valid}, 32'd0);
    check_val("rst_word", {24'd0, word_out}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("rel_rst_n_before_edge", {31'd0, lfsr_rst_n}, 32'd0);
    @(posedge clk); #1;
    check_val("rel_rst_n_after_edge", {31'd0, lfsr_rst_n}, 32'd1);

    run_seq(8'h01, 8'd0, 8'h01, 0, "n0");
    run_seq(8'h01, 8'd3, 8'h08, 0, "n3");
    run_seq(8'h00, 8'd1, 8'hAB, 0, "zero_escape");
    run_seq(8'h05, 8'd2, 8'h14, 20, "hold_stall");
    run_seq(8'h5A, 8'd0, 8'h5A, 0, "back_to_back");

    // Abort in the middle of the unload phase.
    @(negedge clk);
    seed_in = 8'h3C; shift_cycles = 8'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; oe_cnt = 0; k = 0;
    while (oe_cnt < 4 && k < 50) begin
      @(posedge clk); #1;
      k++;
      if (lfsr_out_enable) oe_cnt++;
    end
    check_val("abort_oe_seen", oe_cnt, 32'd4);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check_val("abort_rst_n", {31'd0, lfsr_rst_n}, 32'd0);
    check_val("abort_oe", {31'd0, lfsr_out_enable}, 32'd0);
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    check_val("abort_word", {24'd0, word_out}, 32'd0);
    check_val("abort_seed", {24'd0, lfsr_seed}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (word_valid || busy) bad++;
    end
    check_val("abort_no_valid", bad, 32'd0);
    run_seq(8'h80, 8'd0, 8'h80, 0, "after_abort");

    exp255 = 8'h01;
    for (int i = 0; i < 255; i++) exp255 = lfsr_step(exp255);
    run_seq(8'h01, 8'd255, exp255, 0, "n255");

    check_val("en_oe_exclusive", excl_viol, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
